// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and default geometry for the data-memory responder.
package lsu_pkg;

  localparam int DEFAULT_NUM_LANES = 8;
  localparam int DEFAULT_NUM_BANKS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    RESPOND = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                         is_store;
    logic [1:0]                   warp_num;
    logic [3:0]                   dest_reg;
    logic [DEFAULT_NUM_LANES-1:0] lane_mask;
  } mem_req_t;

endpackage

// File: rtl/bank_arbiter.sv
// rtl/bank_arbiter.sv - per-bank fixed-priority lane arbiter; the lowest pending lane wins each bank.
module bank_arbiter
  import lsu_pkg::*;
#(
  parameter int NUM_LANES = DEFAULT_NUM_LANES,
  parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
  parameter int BANK_BITS = $clog2(NUM_BANKS)
) (
  input  logic [NUM_LANES-1:0]                pending_i,
  input  logic [NUM_LANES-1:0][BANK_BITS-1:0] lane_bank_i,
  output logic [NUM_BANKS-1:0][NUM_LANES-1:0] grant_o,
  output logic [NUM_BANKS-1:0]                grant_valid_o
);

  always_comb begin
    grant_o       = '0;
    grant_valid_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (pending_i[l] && (lane_bank_i[l] == BANK_BITS'(b)) && !grant_valid_o[b]) begin
          grant_o[b][l]    = 1'b1;
          grant_valid_o[b] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - banked warp-wide load/store responder with conflict serialization.
// Optional macro MEM_BANK_CONFLICT_STATS_EN builds the saturating bank-conflict stall counter.
module data_mem_responder
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_LANES  = DEFAULT_NUM_LANES,
  parameter int NUM_BANKS  = DEFAULT_NUM_BANKS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_is_store,
  input  logic [1:0]                           req_warp_num,
  input  logic [3:0]                           req_dest_reg,
  input  logic [NUM_LANES-1:0]                 req_lane_mask,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic                                 resp_valid,
  output logic                                 resp_is_store,
  output logic [1:0]                           resp_warp_num,
  output logic [3:0]                           resp_dest_reg,
  output logic [NUM_LANES-1:0]                 resp_lane_mask,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] resp_rdata,
  output logic [15:0]                          stall_count
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int CNT_W     = $clog2(NUM_LANES + 1);

  mem_state_e                           state_q, state_d;
  mem_req_t                             req_q, req_d;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_LANES-1:0]                 pending_q, pending_d;

  logic [DATA_WIDTH-1:0]                mem [2**ADDR_WIDTH];

  logic [NUM_LANES-1:0][BANK_BITS-1:0]  lane_bank;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0]  bank_grant;
  logic [NUM_BANKS-1:0]                 bank_grant_valid;
  logic [NUM_LANES-1:0]                 lane_grant;

  // Word-interleaved banking: the low address bits select the bank.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_bank[l] = addr_q[l][BANK_BITS-1:0];
    end
  end

  bank_arbiter #(
    .NUM_LANES (NUM_LANES),
    .NUM_BANKS (NUM_BANKS),
    .BANK_BITS (BANK_BITS)
  ) u_bank_arbiter (
    .pending_i     (pending_q),
    .lane_bank_i   (lane_bank),
    .grant_o       (bank_grant),
    .grant_valid_o (bank_grant_valid)
  );

  always_comb begin
    lane_grant = '0;
    if (state_q == SERVICE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_grant_valid[b]) begin
          lane_grant = lane_grant | bank_grant[b];
        end
      end
    end
  end

  // Granted lanes always sit in distinct banks, so no two writes share an address.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_grant[l] && req_q.is_store) begin
        mem[addr_q[l]] <= wdata_q[l];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.is_store  = req_is_store;
          req_d.warp_num  = req_warp_num;
          req_d.dest_reg  = req_dest_reg;
          req_d.lane_mask = req_lane_mask;
          addr_d          = req_addr;
          wdata_d         = req_wdata;
          pending_d       = req_lane_mask;
          rdata_d         = '0;
          state_d         = (req_lane_mask == '0) ? RESPOND : SERVICE;
        end
      end
      SERVICE: begin
        pending_d = pending_q & ~lane_grant;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (lane_grant[l] && !req_q.is_store) begin
            rdata_d[l] = mem[addr_q[l]];
          end
        end
        if (pending_d == '0) begin
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef MEM_BANK_CONFLICT_STATS_EN
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic [15:0]      stall_q, stall_d;
  logic [16:0]      stall_sum;

  // conflict_q counts SERVICE cycles beyond the first, i.e. K-1 for the request.
  always_comb begin
    conflict_d = conflict_q;
    stall_d    = stall_q;
    stall_sum  = {1'b0, stall_q} + 17'(conflict_q);
    case (state_q)
      IDLE:    conflict_d = '0;
      SERVICE: if (pending_d != '0) conflict_d = conflict_q + CNT_W'(1);
      RESPOND: stall_d = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
      default: conflict_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      stall_q    <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESPOND);
  assign resp_is_store  = req_q.is_store;
  assign resp_warp_num  = req_q.warp_num;
  assign resp_dest_reg  = req_q.dest_reg;
  assign resp_lane_mask = req_q.lane_mask;
  assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_warp_num;
  logic [3:0]        req_dest_reg;
  logic [7:0]        req_lane_mask;
  logic [7:0][7:0]   req_addr;
  logic [7:0][15:0]  req_wdata;
  logic              resp_valid;
  logic              resp_is_store;
  logic [1:0]        resp_warp_num;
  logic [3:0]        resp_dest_reg;
  logic [7:0]        resp_lane_mask;
  logic [7:0][15:0]  resp_rdata;
  logic [15:0]       stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_stall = 0;

  int               cap_lat;
  logic [7:0][15:0] cap_rdata;
  logic             cap_is_store;
  logic [1:0]       cap_warp;
  logic [3:0]       cap_dest;
  logic [7:0]       cap_mask;
  logic             cap_after_valid;
  logic             cap_after_ready;

  data_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_warp_num   (req_warp_num),
    .req_dest_reg   (req_dest_reg),
    .req_lane_mask  (req_lane_mask),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_is_store  (resp_is_store),
    .resp_warp_num  (resp_warp_num),
    .resp_dest_reg  (resp_dest_reg),
    .resp_lane_mask (resp_lane_mask),
    .resp_rdata     (resp_rdata),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_stall(input int k);
`ifdef MEM_BANK_CONFLICT_STATS_EN
    exp_stall = exp_stall + k - 1;
`else
    exp_stall = exp_stall + 0 * k;
`endif
  endtask

  task automatic do_req(input logic st, input logic [1:0] w, input logic [3:0] d,
                        input logic [7:0] m, input logic [7:0][7:0] a,
                        input logic [7:0][15:0] wd);
    @(negedge clk);
    req_is_store  = st;
    req_warp_num  = w;
    req_dest_reg  = d;
    req_lane_mask = m;
    req_addr      = a;
    req_wdata     = wd;
    req_valid     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cap_lat   = 0;
    for (int c = 1; c <= 20; c++) begin
      if (resp_valid) begin
        cap_lat      = c;
        cap_rdata    = resp_rdata;
        cap_is_store = resp_is_store;
        cap_warp     = resp_warp_num;
        cap_dest     = resp_dest_reg;
        cap_mask     = resp_lane_mask;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cap_after_valid = resp_valid;
    cap_after_ready = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_warp_num = '0; req_dest_reg = '0;
    req_lane_mask = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({req_ready, resp_valid} !== 2'b10) $display("FAIL reset_hs ready/valid=%b want 10", {req_ready, resp_valid});
    else pass_cnt++;
    total_cnt++;
    if ({resp_is_store, resp_warp_num, resp_dest_reg, resp_lane_mask} !== 15'h0)
      $display("FAIL reset_tags got %h want 0", {resp_is_store, resp_warp_num, resp_dest_reg, resp_lane_mask});
    else pass_cnt++;
    total_cnt++;
    if (resp_rdata !== '0 || stall_count !== 16'h0) $display("FAIL reset_data rdata=%h stall=%h want 0", resp_rdata, stall_count);
    else pass_cnt++;
  endtask

  task automatic test_store_all();
    logic [7:0][7:0] a;
    logic [7:0][15:0] wd;
    for (int i = 0; i < 8; i++) begin a[i] = 8'(i); wd[i] = 16'h0100 + 16'(i); end
    do_req(1'b1, 2'd1, 4'd3, 8'hFF, a, wd);
    add_stall(2);
    total_cnt++;
    if (cap_lat !== 3) $display("FAIL store_all_lat got %0d want 3", cap_lat); else pass_cnt++;
    total_cnt++;
    if (cap_is_store !== 1'b1 || cap_rdata !== '0) $display("FAIL store_all_resp is_store=%b rdata=%h want 1/0", cap_is_store, cap_rdata);
    else pass_cnt++;
    total_cnt++;
    if (cap_after_valid !== 1'b0 || cap_after_ready !== 1'b1) $display("FAIL store_all_pulse valid=%b ready=%b want 0/1", cap_after_valid, cap_after_ready);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'(exp_stall)) $display("FAIL store_all_stall got %0d want %0d", stall_count, exp_stall); else pass_cnt++;
  endtask

  task automatic test_load_all();
    logic [7:0][7:0] a;
    logic [7:0][15:0] exp;
    for (int i = 0; i < 8; i++) begin a[i] = 8'(i); exp[i] = 16'h0100 + 16'(i); end
    do_req(1'b0, 2'd2, 4'd5, 8'hFF, a, '0);
    add_stall(2);
    total_cnt++;
    if (cap_lat !== 3) $display("FAIL load_all_lat got %0d want 3", cap_lat); else pass_cnt++;
    total_cnt++;
    if (cap_rdata !== exp) $display("FAIL load_all_rdata got %h want %h", cap_rdata, exp); else pass_cnt++;
    total_cnt++;
    if ({cap_is_store, cap_warp, cap_dest, cap_mask} !== {1'b0, 2'd2, 4'd5, 8'hFF})
      $display("FAIL load_all_tags got %h want %h", {cap_is_store, cap_warp, cap_dest, cap_mask}, {1'b0, 2'd2, 4'd5, 8'hFF});
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic [7:0][7:0] a;
    logic [7:0][15:0] wd;
    logic [7:0][15:0] exp;
    for (int i = 0; i < 8; i++) begin a[i] = 8'h10; wd[i] = 16'h1000 + 16'(i); exp[i] = 16'h1007; end
    do_req(1'b1, 2'd0, 4'd1, 8'hFF, a, wd);
    add_stall(8);
    total_cnt++;
    if (cap_lat !== 9) $display("FAIL conflict_store_lat got %0d want 9", cap_lat); else pass_cnt++;
    do_req(1'b0, 2'd3, 4'd9, 8'hFF, a, '0);
    add_stall(8);
    total_cnt++;
    if (cap_lat !== 9) $display("FAIL conflict_load_lat got %0d want 9", cap_lat); else pass_cnt++;
    total_cnt++;
    if (cap_rdata !== exp) $display("FAIL conflict_rdata got %h want %h", cap_rdata, exp); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'(exp_stall)) $display("FAIL conflict_stall got %0d want %0d", stall_count, exp_stall); else pass_cnt++;
  endtask

  task automatic test_mask();
    logic [7:0][7:0] a;
    logic [7:0][15:0] wd;
    logic [7:0][15:0] exp;
    for (int i = 0; i < 8; i++) begin a[i] = 8'(i); wd[i] = 16'hDEAD; end
    exp = '0;
    exp[0] = 16'h0100;
    exp[5] = 16'h0105;
    do_req(1'b0, 2'd1, 4'd2, 8'h00, a, '0);
    total_cnt++;
    if (cap_lat !== 1 || cap_rdata !== '0) $display("FAIL mask0_load lat=%0d rdata=%h want 1/0", cap_lat, cap_rdata); else pass_cnt++;
    do_req(1'b1, 2'd1, 4'd2, 8'h00, a, wd);
    total_cnt++;
    if (cap_lat !== 1) $display("FAIL mask0_store_lat got %0d want 1", cap_lat); else pass_cnt++;
    do_req(1'b0, 2'd0, 4'd7, 8'h21, a, '0);
    add_stall(1);
    total_cnt++;
    if (cap_lat !== 2) $display("FAIL mask21_lat got %0d want 2", cap_lat); else pass_cnt++;
    total_cnt++;
    if (cap_rdata !== exp || cap_mask !== 8'h21) $display("FAIL mask21_rdata got %h mask %h want %h mask 21", cap_rdata, cap_mask, exp);
    else pass_cnt++;
  endtask

  task automatic test_same_addr();
    logic [7:0][7:0] a;
    logic [7:0][15:0] wd;
    a = '0; wd = '0;
    a[1] = 8'h20; wd[1] = 16'hAAAA;
    a[5] = 8'h20; wd[5] = 16'h5555;
    do_req(1'b1, 2'd2, 4'd0, 8'h22, a, wd);
    add_stall(2);
    total_cnt++;
    if (cap_lat !== 3) $display("FAIL same_addr_store_lat got %0d want 3", cap_lat); else pass_cnt++;
    a[0] = 8'h20;
    do_req(1'b0, 2'd2, 4'd4, 8'h01, a, '0);
    add_stall(1);
    total_cnt++;
    if (cap_lat !== 2 || cap_rdata[0] !== 16'h5555) $display("FAIL same_addr_load lat=%0d data=%h want 2/5555", cap_lat, cap_rdata[0]);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'(exp_stall)) $display("FAIL same_addr_stall got %0d want %0d", stall_count, exp_stall); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0][7:0] a;
    logic [7:0][15:0] exp;
    logic seen;
    for (int i = 0; i < 8; i++) a[i] = 8'h10;
    @(negedge clk);
    req_is_store = 1'b0; req_warp_num = 2'd1; req_dest_reg = 4'd6;
    req_lane_mask = 8'hFF; req_addr = a; req_wdata = '0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    total_cnt++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL mid_reset_hs valid=%b ready=%b want 0/1", resp_valid, req_ready);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    exp_stall = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0 || req_ready !== 1'b1) $display("FAIL mid_reset_abort seen=%b ready=%b want 0/1", seen, req_ready);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'h0) $display("FAIL mid_reset_stall got %0d want 0", stall_count); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin a[i] = 8'(i); exp[i] = 16'h0100 + 16'(i); end
    do_req(1'b0, 2'd3, 4'd15, 8'hFF, a, '0);
    add_stall(2);
    total_cnt++;
    if (cap_lat !== 3 || cap_rdata !== exp) $display("FAIL post_reset_load lat=%0d rdata=%h want 3/%h", cap_lat, cap_rdata, exp);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'(exp_stall)) $display("FAIL post_reset_stall got %0d want %0d", stall_count, exp_stall); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_all();
    test_load_all();
    test_conflict();
    test_mask();
    test_same_addr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
